gray_counter: RTL and testbench

GRAY_COUNTER -- requirements
Module: gray_counter

---
 rtl/gray_pkg.sv | 22 ++
 rtl/gray_counter_if.sv | 21 ++
 rtl/gray_enc.sv | 13 +
 rtl/gray_counter.sv | 72 +++++++
 tb/tb_gray_counter.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code package: default width and binary<->Gray helpers (16-bit max).
package gray_pkg;

  localparam int unsigned GRAY_W_DEFAULT = 4;
  localparam int unsigned GRAY_W_MAX     = 16;

  // Binary to Gray: each Gray bit is the XOR of adjacent binary bits.
  function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: prefix XOR from the MSB down.
  function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
    logic [GRAY_W_MAX-1:0] b;
    b[GRAY_W_MAX-1] = g[GRAY_W_MAX-1];
    for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Control/status bundle for gray_counter; err_step exists only with GRAY_COUNTER_STEP_CHECK_EN.
interface gray_counter_if #(
  parameter int unsigned WIDTH = gray_pkg::GRAY_W_DEFAULT
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] binary;
  logic [WIDTH-1:0] gray;
  logic             tc;
`ifdef GRAY_COUNTER_STEP_CHECK_EN
  logic             err_step;

  modport master (output en, up, load, load_val, input binary, gray, tc, err_step);
  modport slave  (input en, up, load, load_val, output binary, gray, tc, err_step);
`else
  modport master (output en, up, load, load_val, input binary, gray, tc);
  modport slave  (input en, up, load, load_val, output binary, gray, tc);
`endif
endinterface

// File: rtl/gray_enc.sv
// Combinational binary-to-Gray encoder on the counter's next-state path.
module gray_enc
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_W_DEFAULT
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray_c
);

  assign gray_c = WIDTH'(bin2gray(GRAY_W_MAX'(bin)));

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with registered Gray output (WIDTH 2..16).
// Optional sticky step checker: define GRAY_COUNTER_STEP_CHECK_EN.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  gray_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;

  // Next binary: load beats count, count beats hold.
  always_comb begin
    bin_next = bin_q;
    if (bus.load) begin
      bin_next = bus.load_val;
    end else if (bus.en) begin
      bin_next = bus.up ? (bin_q + ONE) : (bin_q - ONE);
    end
  end

  // Gray is derived from the next binary so both registers update together.
  gray_enc #(.WIDTH(WIDTH)) u_enc (
    .bin    (bin_next),
    .gray_c (gray_next)
  );

  // Count state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_next;
      gray_q <= gray_next;
    end
  end

  assign bus.binary = bin_q;
  assign bus.gray   = gray_q;
  assign bus.tc     = bus.en & ((bus.up & (bin_q == ALL_ONES)) | (~bus.up & (bin_q == '0)));

`ifdef GRAY_COUNTER_STEP_CHECK_EN
  logic [WIDTH-1:0] gray_diff;
  logic             one_bit_step;
  logic             err_q;

  assign gray_diff    = gray_next ^ gray_q;
  assign one_bit_step = (gray_diff != '0) && ((gray_diff & (gray_diff - ONE)) == '0);

  // Sticky flag on any counting edge whose Gray step is not a single-bit change; loads are exempt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (bus.en && !bus.load && !one_bit_step) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err_step = err_q;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Directed testbench for gray_counter (WIDTH=4) with hand-computed expectations.
module tb_gray_counter;

  localparam int unsigned W = 4;

  // Gray sequence for binary 0..15.
  localparam logic [3:0] GSEQ [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                        4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   errors  = 0;

  gray_counter_if #(.WIDTH(W)) bus ();

  gray_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic u, input logic l, input logic [3:0] v);
    bus.en       = e;
    bus.up       = u;
    bus.load     = l;
    bus.load_val = v;
  endtask

  task automatic check_state(input string tag, input logic [3:0] b, input logic [3:0] g);
    check({tag, ".binary"}, 16'(bus.binary), 16'(b));
    check({tag, ".gray"},   16'(bus.gray),   16'(g));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    #1;
    check_state("reset", 4'h0, 4'h0);
    check("reset.tc", 16'(bus.tc), 16'h0);
`ifdef GRAY_COUNTER_STEP_CHECK_EN
    check("reset.err_step", 16'(bus.err_step), 16'h0);
`endif
    tick();
    rst_n = 1'b1;

    // Full up-count through wrap.
    drive(1'b1, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 16; i++) begin
      #1;
      check($sformatf("up%0d.tc", i), 16'(bus.tc), (i == 15) ? 16'h1 : 16'h0);
      tick();
      check_state($sformatf("up%0d", i), 4'((i + 1) % 16), GSEQ[(i + 1) % 16]);
    end

    // Down wrap from zero.
    drive(1'b1, 1'b0, 1'b0, 4'h0);
    #1;
    check("dnwrap.tc_at0", 16'(bus.tc), 16'h1);
    tick();
    check_state("dnwrap", 4'hF, 4'h8);
    check("dnwrap.tc_atF", 16'(bus.tc), 16'h0);

    // Direction change takes effect immediately: F up -> 0, then down -> F, down -> E.
    drive(1'b1, 1'b1, 1'b0, 4'h0);
    #1;
    check("dir.tc_upF", 16'(bus.tc), 16'h1);
    tick();
    check_state("dir.up", 4'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h0);
    tick();
    check_state("dir.dn1", 4'hF, 4'h8);
    tick();
    check_state("dir.dn2", 4'hE, 4'h9);

    // Load wins over count.
    drive(1'b1, 1'b1, 1'b1, 4'hA);
    tick();
    check_state("load_en_up", 4'hA, 4'hF);
    drive(1'b1, 1'b0, 1'b1, 4'h3);
    tick();
    check_state("load_en_dn", 4'h3, 4'h2);
    drive(1'b0, 1'b0, 1'b1, 4'hC);
    tick();
    check_state("load_noen", 4'hC, 4'hA);

    // Hold at 0111 for 5 cycles.
    drive(1'b0, 1'b1, 1'b1, 4'h7);
    tick();
    drive(1'b0, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_state($sformatf("hold%0d", i), 4'h7, 4'h4);
      check($sformatf("hold%0d.tc", i), 16'(bus.tc), 16'h0);
    end

    // Count up to 0101, then asynchronous reset between edges.
    drive(1'b0, 1'b1, 1'b1, 4'h3);
    tick();
    drive(1'b1, 1'b1, 1'b0, 4'h0);
    tick();
    tick();
    check_state("pre_rst", 4'h5, 4'h7);
    #2;
    rst_n = 1'b0;
    #1;
    check_state("async_rst", 4'h0, 4'h0);
    drive(1'b1, 1'b1, 1'b1, 4'h9);
    tick();
    check_state("rst_held", 4'h0, 4'h0);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 4'h0);
    tick();
    check_state("post_rst", 4'h1, 4'h1);

`ifdef GRAY_COUNTER_STEP_CHECK_EN
    // Free run with random direction, then a multi-bit jump via load followed by counting.
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 4'h0);
      tick();
    end
    check("freerun.err_step", 16'(bus.err_step), 16'h0);
    drive(1'b0, 1'b0, 1'b1, 4'h0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 4'h5);
    tick();
    check_state("jump", 4'h5, 4'h7);
    drive(1'b1, 1'b1, 1'b0, 4'h0);
    tick();
    tick();
    check_state("jump_cnt", 4'h7, 4'h4);
    check("jump.err_step", 16'(bus.err_step), 16'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
